itr_ctrl: RTL and testbench

Interrupt controller that sequences the processor's single `itr` input from NSRC synchronous event sources.
- Latches rising edges into pending bits and applies a software-written mask.
- Raises `itr` toward the core and waits for the ISR to acknowledge by reading a status word through the core's input port.
- Enforces a holdoff gap before the next interrupt.
- Sits beside the processor on its I/O bus: snoops io_out/addr_out/out_en and answers req_in/addr_in reads at its own address.

---
 rtl/itr_ctrl_pkg.sv | 22 ++
 rtl/itr_prio_enc.sv | 26 ++
 rtl/itr_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_itr_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itr_ctrl_pkg.sv
// itr_ctrl_pkg: shared types and helpers for the interrupt controller.
//   itr_state_e    - sequencer states (idle, itr asserted, waiting for ack, holdoff gap)
//   stat_valid_bit - bit position of the "interrupt pending" flag in the status word
//   id_width       - width of the source-id field in the status word
package itr_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StWaitAck,
        StHoldoff
    } itr_state_e;

    function automatic int unsigned stat_valid_bit(input int unsigned nubits);
        return nubits - 1;
    endfunction

    function automatic int unsigned id_width(input int unsigned nsrc);
        return (nsrc > 1) ? $clog2(nsrc) : 1;
    endfunction

endpackage

// File: rtl/itr_prio_enc.sv
// itr_prio_enc: combinational lowest-index-first priority encoder.
// Ports:
//   req  in  NSRC  request vector
//   any  out 1     at least one request set
//   sel  out IDW   index of the lowest set request (0 when none)
module itr_prio_enc #(
    parameter int unsigned NSRC = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NSRC-1:0] req,
    output logic            any,
    output logic [IDW-1:0]  sel
);

    always_comb begin
        any = |req;
        sel = '0;
        // Scan downward so the lowest set index is written last.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/itr_ctrl.sv
// itr_ctrl: sequences the core's single itr input from NSRC synchronous event sources.
// Rising edges latch into pending bits, a software mask gates them, itr is held high for
// ITRLEN cycles, the ISR acks by reading the status word, then HOLDOFF idle cycles follow.
// Optional feature: define ITR_LOST_CNT_EN to add a saturating lost-event counter readable
// (and cleared) at input address STAT_ADDR+1; otherwise that address reads 0.
// Ports:
//   clk       in  1       system clock
//   rst       in  1       synchronous reset, active low
//   src       in  NSRC    event sources
//   io_out    in  NUBITS  processor output data (mask writes)
//   addr_out  in  clog2(NUIOOU) processor output address
//   out_en    in  1       processor output strobe
//   addr_in   in  clog2(NUIOIN) processor input address
//   req_in    in  1       processor input request (read/ack strobe)
//   io_in     out NUBITS  read data, 0 when not addressed
//   itr       out 1       interrupt to the core
module itr_ctrl
    import itr_ctrl_pkg::*;
#(
    parameter int unsigned NUBITS    = 16,
    parameter int unsigned NSRC      = 4,
    parameter int unsigned NUIOIN    = 2,
    parameter int unsigned NUIOOU    = 2,
    parameter int unsigned STAT_ADDR = 0,
    parameter int unsigned MASK_ADDR = 0,
    parameter int unsigned ITRLEN    = 2,
    parameter int unsigned HOLDOFF   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NSRC-1:0]           src,
    input  logic [NUBITS-1:0]         io_out,
    input  logic [$clog2(NUIOOU)-1:0] addr_out,
    input  logic                      out_en,
    input  logic [$clog2(NUIOIN)-1:0] addr_in,
    input  logic                      req_in,
    output logic [NUBITS-1:0]         io_in,
    output logic                      itr
);

    localparam int unsigned IdW    = id_width(NSRC);
    localparam int unsigned VldBit = stat_valid_bit(NUBITS);
    localparam int unsigned AiW    = $clog2(NUIOIN);
    localparam int unsigned AoW    = $clog2(NUIOOU);
    localparam int unsigned CntMax = (ITRLEN > HOLDOFF) ? ITRLEN : HOLDOFF;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [AiW-1:0] StatAddr = AiW'(STAT_ADDR);
    localparam logic [AoW-1:0] MaskAddr = AoW'(MASK_ADDR);

    logic [NSRC-1:0]   src_q, pend_q, mask_q;
    logic [NSRC-1:0]   rise, act, clr, pend_d;
    logic              any;
    logic [IdW-1:0]    sel;
    logic              stat_hit;
    logic [NUBITS-1:0] stat_word;

    itr_state_e        state_q;
    logic [CntW-1:0]   cnt_q;
    logic              acked_q;
    logic              itr_q;

    itr_prio_enc #(
        .NSRC (NSRC),
        .IDW  (IdW)
    ) u_prio_enc (
        .req (act),
        .any (any),
        .sel (sel)
    );

    always_comb begin
        rise     = src & ~src_q;
        act      = pend_q & mask_q;
        stat_hit = req_in && (addr_in == StatAddr);
        clr      = '0;
        if (stat_hit && any) begin
            clr[sel] = 1'b1;
        end
        // A coincident rise wins over the ack clear.
        pend_d = (pend_q & ~clr) | rise;

        stat_word         = '0;
        stat_word[VldBit] = any;
        if (any) begin
            stat_word[IdW-1:0] = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            src_q  <= '0;
            pend_q <= '0;
            mask_q <= '0;
        end else begin
            src_q  <= src;
            pend_q <= pend_d;
            if (out_en && (addr_out == MaskAddr)) begin
                mask_q <= io_out[NSRC-1:0];
            end
        end
    end

`ifdef ITR_LOST_CNT_EN
    localparam logic [AiW-1:0] LostAddr = AiW'(STAT_ADDR + 1);

    logic [NUBITS-1:0] lost_q;
    logic              lost_inc;
    logic              lost_rd;

    always_comb begin
        lost_inc = |(rise & pend_q & ~clr);
        lost_rd  = req_in && (addr_in == LostAddr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lost_q <= '0;
        end else if (lost_rd) begin
            lost_q <= '0;
        end else if (lost_inc && (lost_q != '1)) begin
            lost_q <= lost_q + NUBITS'(1);
        end
    end

    always_comb begin
        io_in = '0;
        if (addr_in == StatAddr) begin
            io_in = stat_word;
        end else if (addr_in == LostAddr) begin
            io_in = lost_q;
        end
    end
`else
    always_comb begin
        io_in = '0;
        if (addr_in == StatAddr) begin
            io_in = stat_word;
        end
    end
`endif

    // Any status read is an ack for the sequencer, even when nothing is pending, so an ISR
    // that finds everything masked still releases the wait.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acked_q <= 1'b0;
            itr_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any) begin
                        state_q <= StAssert;
                        cnt_q   <= CntW'(ITRLEN - 1);
                        acked_q <= 1'b0;
                        itr_q   <= 1'b1;
                    end
                end
                StAssert: begin
                    if (stat_hit) begin
                        acked_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        itr_q <= 1'b0;
                        if (acked_q || stat_hit) begin
                            if (HOLDOFF == 0) begin
                                state_q <= StIdle;
                            end else begin
                                state_q <= StHoldoff;
                                cnt_q   <= CntW'(HOLDOFF - 1);
                            end
                        end else begin
                            state_q <= StWaitAck;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StWaitAck: begin
                    if (stat_hit) begin
                        if (HOLDOFF == 0) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StHoldoff;
                            cnt_q   <= CntW'(HOLDOFF - 1);
                        end
                    end
                end
                StHoldoff: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign itr = itr_q;

endmodule

// File: tb/tb_itr_ctrl.sv
// Self-checking bench for itr_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a timeline model of the controller.
module tb_itr_ctrl;

    localparam int unsigned NUBITS    = 16;
    localparam int unsigned NSRC      = 4;
    localparam int unsigned ITRLEN    = 2;
    localparam int unsigned HOLDOFF   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src;
    logic [15:0] io_out;
    logic [0:0]  addr_out;
    logic        out_en;
    logic [0:0]  addr_in;
    logic        req_in;
    logic [15:0] io_in;
    logic        itr;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    itr_ctrl #(
        .NUBITS    (NUBITS),
        .NSRC      (NSRC),
        .NUIOIN    (2),
        .NUIOOU    (2),
        .STAT_ADDR (0),
        .MASK_ADDR (0),
        .ITRLEN    (ITRLEN),
        .HOLDOFF   (HOLDOFF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src      (src),
        .io_out   (io_out),
        .addr_out (addr_out),
        .out_en   (out_en),
        .addr_in  (addr_in),
        .req_in   (req_in),
        .io_in    (io_in),
        .itr      (itr)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // The sequencer is tracked as remaining-time budgets: cycles of itr left, whether an
    // ack is still owed, and cycles of holdoff gap left.
    logic [3:0]  m_src_q, m_pend, m_mask;
    logic [15:0] m_lost;
    int          m_itr_left, m_gap;
    bit          m_need_ack, m_ack_seen;

    function automatic logic [15:0] m_status();
        logic [3:0] a;
        a = m_pend & m_mask;
        for (int i = 0; i < 4; i++) begin
            if (a[i]) return 16'h8000 + 16'(i);
        end
        return 16'h0000;
    endfunction

    function automatic logic [15:0] m_io_exp();
        if (addr_in == 1'b0) return m_status();
`ifdef ITR_LOST_CNT_EN
        return m_lost;
`else
        return 16'h0000;
`endif
    endfunction

    always @(posedge clk) begin
        logic [3:0]  a, rise, clr;
        logic [15:0] st;
        bit          hit, any;
        int          sel;
        started = 1'b1;
        if (!rst) begin
            m_src_q = '0; m_pend = '0; m_mask = '0; m_lost = '0;
            m_itr_left = 0; m_gap = 0; m_need_ack = 0; m_ack_seen = 0;
        end else begin
            st   = m_status();
            any  = st[15];
            sel  = int'(st[1:0]);
            hit  = req_in && (addr_in == 1'b0);
            rise = src & ~m_src_q;
            clr  = (hit && any) ? (4'b0001 << sel) : 4'b0000;
            if (req_in && addr_in == 1'b1) m_lost = '0;
            else if (((rise & m_pend & ~clr) != 0) && m_lost != 16'hffff) m_lost = m_lost + 1;
            m_pend  = (m_pend & ~clr) | rise;
            if (out_en && addr_out == 1'b0) m_mask = io_out[3:0];
            m_src_q = src;
            if (m_itr_left > 0) begin
                if (hit) m_ack_seen = 1;
                m_itr_left--;
                if (m_itr_left == 0) begin
                    if (m_ack_seen) m_gap = HOLDOFF;
                    else m_need_ack = 1;
                end
            end else if (m_need_ack) begin
                if (hit) begin
                    m_need_ack = 0;
                    m_gap = HOLDOFF;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (any) begin
                m_itr_left = ITRLEN;
                m_ack_seen = 0;
            end
        end
    end

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Continuous comparison on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            check("itr", {15'b0, itr}, {15'b0, (m_itr_left > 0)});
            check("io_in", io_in, m_io_exp());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the DUT and the model against the same hand-computed value.
    task automatic pin_itr(input string nm, input bit lit);
        check({nm, "_dut"}, {15'b0, itr}, {15'b0, lit});
        check({nm, "_model"}, {15'b0, (m_itr_left > 0)}, {15'b0, lit});
    endtask

    task automatic write_mask(input logic [3:0] m);
        out_en = 1'b1; addr_out = 1'b0; io_out = {12'h0, m};
        tick();
        out_en = 1'b0; io_out = '0;
    endtask

    task automatic rd(input logic [0:0] a, output logic [15:0] d);
        addr_in = a; req_in = 1'b1;
        #1 d = io_in;
        tick();
        req_in = 1'b0; addr_in = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] s);
        src = s;
        tick();
        src = '0;
    endtask

    task automatic wait_itr(input bit lvl, input int max, input string nm);
        for (int n = 0; n < max && itr !== lvl; n++) tick();
        check(nm, {15'b0, itr}, {15'b0, lvl});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0] d;
        int gap;
        rst = 1'b0; src = '0; io_out = '0; addr_out = '0; out_en = 1'b0;
        addr_in = '0; req_in = 1'b0;
        do_reset();
        check("reset_itr", {15'b0, itr}, 16'h0000);
        check("reset_stat", io_in, 16'h0000);

        // Single source, exact latency and itr width.
        write_mask(4'b0001);
        tick();
        pulse(4'b0001);
        pin_itr("t1_pend_cycle", 1'b0);
        tick(); pin_itr("t1_itr_a", 1'b1);
        tick(); pin_itr("t1_itr_b", 1'b1);
        tick(); pin_itr("t1_itr_end", 1'b0);
        rd(1'b0, d);
        check("t1_stat", d, 16'h8000);
        check("t1_cleared", io_in, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            pin_itr("t1_holdoff", 1'b0);
            tick();
        end

        // Two simultaneous sources, lowest index first.
        write_mask(4'b1111);
        pulse(4'b0110);
        wait_itr(1'b1, 10, "t2_itr1_rise");
        wait_itr(1'b0, 10, "t2_itr1_fall");
        rd(1'b0, d);
        check("t2_stat1", d, 16'h8001);
        gap = 0;
        while (itr !== 1'b1 && gap < 30) begin
            tick();
            gap++;
        end
        check("t2_gap", {15'b0, (gap >= HOLDOFF && gap < 30)}, 16'h0001);
        wait_itr(1'b0, 10, "t2_itr2_fall");
        rd(1'b0, d);
        check("t2_stat2", d, 16'h8002);

        // Masked source accumulates and fires once unmasked.
        repeat (8) tick();
        write_mask(4'b0000);
        pulse(4'b1000);
        repeat (6) tick();
        pin_itr("t3_masked", 1'b0);
        write_mask(4'b1000);
        wait_itr(1'b1, 5, "t3_itr_rise");
        wait_itr(1'b0, 5, "t3_itr_fall");
        rd(1'b0, d);
        check("t3_stat", d, 16'h8003);

        // Rise coinciding with the ack of the same source keeps it pending.
        repeat (8) tick();
        write_mask(4'b0001);
        pulse(4'b0001);
        wait_itr(1'b1, 10, "t4_itr1_rise");
        wait_itr(1'b0, 10, "t4_itr1_fall");
        src = 4'b0001;
        rd(1'b0, d);
        src = '0;
        check("t4_stat1", d, 16'h8000);
        check("t4_still_pend", io_in, 16'h8000);
        wait_itr(1'b1, 20, "t4_itr2_rise");
        wait_itr(1'b0, 10, "t4_itr2_fall");
        rd(1'b0, d);
        check("t4_stat2", d, 16'h8000);

        // Reset during ASSERT.
        repeat (8) tick();
        pulse(4'b0001);
        wait_itr(1'b1, 10, "t5_itr_rise");
        rst = 1'b0;
        tick();
        rst = 1'b1;
        pin_itr("t5_rst_itr", 1'b0);
        check("t5_rst_stat", io_in, 16'h0000);
        write_mask(4'b1111);
        repeat (8) tick();
        pin_itr("t5_no_itr", 1'b0);

        // Reset during HOLDOFF.
        pulse(4'b0001);
        wait_itr(1'b1, 10, "t5b_itr_rise");
        wait_itr(1'b0, 10, "t5b_itr_fall");
        rd(1'b0, d);
        check("t5b_stat", d, 16'h8000);
        tick();
        pulse(4'b0010);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        pin_itr("t5b_rst_itr", 1'b0);
        check("t5b_rst_stat", io_in, 16'h0000);
        write_mask(4'b1111);
        repeat (8) tick();
        pin_itr("t5b_no_itr", 1'b0);

        // Repeated rises on a pending source.
        for (int i = 0; i < 3; i++) begin
            pulse(4'b0010);
            tick();
        end
        rd(1'b1, d);
`ifdef ITR_LOST_CNT_EN
        check("t6_lost", d, 16'h0002);
`else
        check("t6_lost_absent", d, 16'h0000);
`endif
        rd(1'b1, d);
        check("t6_lost_clr", d, 16'h0000);
        wait_itr(1'b0, 10, "t6_itr_fall");
        rd(1'b0, d);
        check("t6_stat", d, 16'h8001);

        // Randomized traffic, checked by the continuous comparison.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) src = 4'($urandom);
            out_en   = ($urandom_range(0, 9) == 0);
            addr_out = 1'($urandom);
            io_out   = 16'($urandom);
            req_in   = ($urandom_range(0, 4) == 0);
            addr_in  = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            rst      = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst = 1'b1; src = '0; out_en = 1'b0; req_in = 1'b0; addr_in = '0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
